// File: rtl/rob_pkg.sv
// Shared defines for the reorder buffer: data and GPR index widths, default depth, entry fields.
// The optional feature macro ROB_WB_BYPASS_EN is consumed in rob.sv.
package rob_pkg;

  localparam int WORD_WIDTH        = 32;
  localparam int GPR_ADDR_WIDTH    = 5;
  localparam int ROB_DEPTH_DEFAULT = 8;
  localparam int ROB_TAG_DEFAULT   = $clog2(ROB_DEPTH_DEFAULT);

  typedef struct packed {
    logic                      valid;
    logic                      done;
    logic                      has_dst;
    logic [GPR_ADDR_WIDTH-1:0] dst_addr;
    logic [WORD_WIDTH-1:0]     value;
  } rob_entry_t;

endpackage

// File: rtl/rob.sv
// Reorder buffer: in-order allocate, out-of-order writeback, in-order retire onto the GPR commit port.
// Define ROB_WB_BYPASS_EN to let a writeback that targets the head retire in the same cycle.
module rob
  import rob_pkg::*;
#(
  parameter int ROB_DEPTH = ROB_DEPTH_DEFAULT,
  parameter int TAG_WIDTH = ROB_TAG_DEFAULT
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      alloc_valid,
  input  logic                      alloc_has_dst,
  input  logic [GPR_ADDR_WIDTH-1:0] alloc_dst_addr,
  output logic                      alloc_ready,
  output logic [TAG_WIDTH-1:0]      alloc_tag,
  input  logic                      wb_valid,
  input  logic [TAG_WIDTH-1:0]      wb_tag,
  input  logic [WORD_WIDTH-1:0]     wb_value,
  input  logic                      flush,
  output logic                      commit_valid,
  output logic [TAG_WIDTH-1:0]      commit_tag,
  output logic                      commit_en,
  output logic [GPR_ADDR_WIDTH-1:0] rob_commit_dst_addr,
  output logic [WORD_WIDTH-1:0]     rob_commit_dst_value,
  output logic                      rob_empty,
  output logic [TAG_WIDTH:0]        rob_count
);

  rob_entry_t             r_entry [ROB_DEPTH];
  logic [TAG_WIDTH-1:0]   r_head;
  logic [TAG_WIDTH-1:0]   r_tail;
  logic [TAG_WIDTH:0]     r_count;

  rob_entry_t             w_head;
  logic                   w_bypass;
  logic                   w_alloc_fire;
  logic                   w_commit_fire;
  logic [WORD_WIDTH-1:0]  w_commit_value;

  assign w_head = r_entry[r_head];

`ifdef ROB_WB_BYPASS_EN
  assign w_bypass = wb_valid && (wb_tag == r_head) && w_head.valid && !w_head.done;
`else
  assign w_bypass = 1'b0;
`endif

  // A full buffer stays full for the whole cycle, even if the head retires.
  assign alloc_ready    = (r_count != (TAG_WIDTH+1)'(ROB_DEPTH));
  assign alloc_tag      = r_tail;
  assign w_alloc_fire   = alloc_valid && alloc_ready && !flush;
  assign w_commit_fire  = w_head.valid && (w_head.done || w_bypass) && !flush;
  assign w_commit_value = w_bypass ? wb_value : w_head.value;

  assign commit_valid = w_commit_fire;
  assign commit_tag   = w_commit_fire ? r_head : '0;
  // x0 is hardwired, so retirements targeting it never reach the register file.
  assign commit_en    = w_commit_fire && w_head.has_dst && (w_head.dst_addr != '0);
  assign rob_commit_dst_addr  = commit_en ? w_head.dst_addr : '0;
  assign rob_commit_dst_value = commit_en ? w_commit_value : '0;
  assign rob_empty    = (r_count == '0);
  assign rob_count    = r_count;

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_alloc_fire) begin
        r_tail <= r_tail + 1'b1;
      end
      if (w_commit_fire) begin
        r_head <= r_head + 1'b1;
      end
      case ({w_alloc_fire, w_commit_fire})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Writeback is judged against the pre-edge state; an entry allocated this
  // cycle was invalid, so a stray writeback to it cannot mark it done.
  always_ff @(posedge clk) begin
    for (int i = 0; i < ROB_DEPTH; i++) begin
      if (rst || flush) begin
        r_entry[i].valid <= 1'b0;
        r_entry[i].done  <= 1'b0;
      end else if (w_alloc_fire && (r_tail == TAG_WIDTH'(i))) begin
        r_entry[i].valid    <= 1'b1;
        r_entry[i].done     <= 1'b0;
        r_entry[i].has_dst  <= alloc_has_dst;
        r_entry[i].dst_addr <= alloc_dst_addr;
      end else if (w_commit_fire && (r_head == TAG_WIDTH'(i))) begin
        r_entry[i].valid <= 1'b0;
        r_entry[i].done  <= 1'b0;
      end else if (wb_valid && (wb_tag == TAG_WIDTH'(i)) &&
                   r_entry[i].valid && !r_entry[i].done) begin
        r_entry[i].done  <= 1'b1;
        r_entry[i].value <= wb_value;
      end
    end
  end

endmodule

// File: tb/tb_rob.sv
// Directed self-checking bench for rob; the bypass scenario runs only when ROB_WB_BYPASS_EN is defined.
module tb_rob;
  import rob_pkg::*;

  logic                      clk = 1'b0;
  logic                      rst;
  logic                      alloc_valid;
  logic                      alloc_has_dst;
  logic [GPR_ADDR_WIDTH-1:0] alloc_dst_addr;
  logic                      alloc_ready;
  logic [2:0]                alloc_tag;
  logic                      wb_valid;
  logic [2:0]                wb_tag;
  logic [WORD_WIDTH-1:0]     wb_value;
  logic                      flush;
  logic                      commit_valid;
  logic [2:0]                commit_tag;
  logic                      commit_en;
  logic [GPR_ADDR_WIDTH-1:0] rob_commit_dst_addr;
  logic [WORD_WIDTH-1:0]     rob_commit_dst_value;
  logic                      rob_empty;
  logic [3:0]                rob_count;

  int n_checks = 0;
  int n_fail   = 0;

  rob #(.ROB_DEPTH(8), .TAG_WIDTH(3)) dut (
    .clk                  (clk),
    .rst                  (rst),
    .alloc_valid          (alloc_valid),
    .alloc_has_dst        (alloc_has_dst),
    .alloc_dst_addr       (alloc_dst_addr),
    .alloc_ready          (alloc_ready),
    .alloc_tag            (alloc_tag),
    .wb_valid             (wb_valid),
    .wb_tag               (wb_tag),
    .wb_value             (wb_value),
    .flush                (flush),
    .commit_valid         (commit_valid),
    .commit_tag           (commit_tag),
    .commit_en            (commit_en),
    .rob_commit_dst_addr  (rob_commit_dst_addr),
    .rob_commit_dst_value (rob_commit_dst_value),
    .rob_empty            (rob_empty),
    .rob_count            (rob_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    alloc_valid    = 1'b0;
    alloc_has_dst  = 1'b0;
    alloc_dst_addr = '0;
    wb_valid       = 1'b0;
    wb_tag         = '0;
    wb_value       = '0;
    flush          = 1'b0;
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    #1;
  endtask

  task automatic alloc(input logic has_dst, input logic [4:0] dst, input logic [2:0] exp_tag);
    alloc_valid    = 1'b1;
    alloc_has_dst  = has_dst;
    alloc_dst_addr = dst;
    #1;
    chk("alloc_tag", 32'(alloc_tag), 32'(exp_tag));
    $display("alloc dst=%0d has_dst=%0b tag=%0d", dst, has_dst, alloc_tag);
    step();
    idle();
  endtask

  task automatic expect_commit(input logic [2:0] tag, input logic en,
                               input logic [4:0] addr, input logic [31:0] val);
    #1;
    chk("commit_valid", 32'(commit_valid), 32'd1);
    chk("commit_tag", 32'(commit_tag), 32'(tag));
    chk("commit_en", 32'(commit_en), 32'(en));
    chk("commit_addr", 32'(rob_commit_dst_addr), 32'(addr));
    chk("commit_value", rob_commit_dst_value, val);
    $display("commit tag=%0d en=%0b addr=%0d value=%08h", commit_tag, commit_en,
             rob_commit_dst_addr, rob_commit_dst_value);
  endtask

  initial begin
    idle();
    rst = 1'b0;
    do_reset();

    // reset state
    chk("rst_alloc_ready", 32'(alloc_ready), 32'd1);
    chk("rst_empty", 32'(rob_empty), 32'd1);
    chk("rst_count", 32'(rob_count), 32'd0);
    chk("rst_alloc_tag", 32'(alloc_tag), 32'd0);
    chk("rst_commit_valid", 32'(commit_valid), 32'd0);
    chk("rst_commit_en", 32'(commit_en), 32'd0);
    chk("rst_commit_value", rob_commit_dst_value, 32'd0);

    // single instruction
    alloc(1'b1, 5'd5, 3'd0);
    chk("single_count", 32'(rob_count), 32'd1);
    wb_valid = 1'b1; wb_tag = 3'd0; wb_value = 32'hDEADBEEF;
    #1;
`ifndef ROB_WB_BYPASS_EN
    chk("single_no_same_cycle", 32'(commit_valid), 32'd0);
    step();
    idle();
`endif
    expect_commit(3'd0, 1'b1, 5'd5, 32'hDEADBEEF);
    step();
    idle();
    #1;
    chk("single_empty", 32'(rob_empty), 32'd1);
    chk("single_commit_off", 32'(commit_valid), 32'd0);

`ifndef ROB_WB_BYPASS_EN
    // out-of-order completion, in-order retirement
    do_reset();
    alloc(1'b1, 5'd1, 3'd0);
    alloc(1'b1, 5'd2, 3'd1);
    alloc(1'b1, 5'd3, 3'd2);
    wb_valid = 1'b1; wb_tag = 3'd2; wb_value = 32'h22;
    step();
    chk("ooo_wait2", 32'(commit_valid), 32'd0);
    wb_tag = 3'd1; wb_value = 32'h11;
    step();
    chk("ooo_wait1", 32'(commit_valid), 32'd0);
    wb_tag = 3'd0; wb_value = 32'h10;
    step();
    idle();
    expect_commit(3'd0, 1'b1, 5'd1, 32'h10);
    step();
    expect_commit(3'd1, 1'b1, 5'd2, 32'h11);
    step();
    expect_commit(3'd2, 1'b1, 5'd3, 32'h22);
    step();
    chk("ooo_empty", 32'(rob_empty), 32'd1);

    // full buffer and wrap
    do_reset();
    for (int i = 0; i < 8; i++) alloc(1'b1, 5'(i + 1), 3'(i));
    chk("full_count", 32'(rob_count), 32'd8);
    chk("full_ready", 32'(alloc_ready), 32'd0);
    wb_valid = 1'b1; wb_tag = 3'd0; wb_value = 32'hA0;
    step();
    idle();
    alloc_valid = 1'b1; alloc_has_dst = 1'b1; alloc_dst_addr = 5'd9;
    #1;
    chk("full_commit_ready", 32'(alloc_ready), 32'd0);
    expect_commit(3'd0, 1'b1, 5'd1, 32'hA0);
    step();
    chk("full_refused_count", 32'(rob_count), 32'd7);
    chk("wrap_ready", 32'(alloc_ready), 32'd1);
    chk("wrap_tag", 32'(alloc_tag), 32'd0);
    step();
    idle();
    chk("wrap_count", 32'(rob_count), 32'd8);
    chk("wrap_head_tag1_pending", 32'(commit_valid), 32'd0);

    // reset mid-operation drops everything
    do_reset();
    chk("midrst_count", 32'(rob_count), 32'd0);
    chk("midrst_empty", 32'(rob_empty), 32'd1);

    // x0 and no-destination retirements
    alloc(1'b1, 5'd0, 3'd0);
    alloc(1'b0, 5'd7, 3'd1);
    wb_valid = 1'b1; wb_tag = 3'd0; wb_value = 32'h55;
    step();
    wb_tag = 3'd1; wb_value = 32'h66;
    expect_commit(3'd0, 1'b0, 5'd0, 32'd0);
    step();
    idle();
    expect_commit(3'd1, 1'b0, 5'd0, 32'd0);
    step();
    chk("nodst_empty", 32'(rob_empty), 32'd1);

    // flush while head is ready
    alloc(1'b1, 5'd4, 3'd2);
    alloc(1'b1, 5'd6, 3'd3);
    wb_valid = 1'b1; wb_tag = 3'd2; wb_value = 32'h77;
    step();
    idle();
    flush = 1'b1;
    #1;
    chk("flush_commit_valid", 32'(commit_valid), 32'd0);
    chk("flush_commit_en", 32'(commit_en), 32'd0);
    $display("flush count_before=%0d", rob_count);
    step();
    idle();
    chk("flush_count", 32'(rob_count), 32'd0);
    chk("flush_empty", 32'(rob_empty), 32'd1);
    chk("flush_alloc_tag", 32'(alloc_tag), 32'd0);
    wb_valid = 1'b1; wb_tag = 3'd3; wb_value = 32'h99;
    step();
    idle();
    chk("late_wb_count", 32'(rob_count), 32'd0);
    chk("late_wb_commit", 32'(commit_valid), 32'd0);
    alloc(1'b1, 5'd5, 3'd0);
    chk("post_flush_not_done", 32'(commit_valid), 32'd0);
    wb_valid = 1'b1; wb_tag = 3'd0; wb_value = 32'hBB;
    step();
    idle();
    expect_commit(3'd0, 1'b1, 5'd5, 32'hBB);
    step();
    chk("post_flush_empty", 32'(rob_empty), 32'd1);
`else
    // same-cycle bypass of a writeback to the head
    do_reset();
    for (int i = 0; i < 4; i++) alloc(1'b1, 5'(i + 1), 3'(i));
    for (int i = 0; i < 3; i++) begin
      wb_valid = 1'b1; wb_tag = 3'(i); wb_value = 32'(i + 1);
      expect_commit(3'(i), 1'b1, 5'(i + 1), 32'(i + 1));
      step();
    end
    wb_valid = 1'b1; wb_tag = 3'd3; wb_value = 32'h1234;
    expect_commit(3'd3, 1'b1, 5'd4, 32'h1234);
    step();
    idle();
    chk("bypass_empty", 32'(rob_empty), 32'd1);
    chk("bypass_commit_off", 32'(commit_valid), 32'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/rob.md
# rob

Reorder buffer for the out-of-order core. Allocates one entry per dispatched instruction in program order, collects results from the execution units' writeback bus, and retires the oldest completed entry each cycle. Retirement drives the GPR commit write port (`commit_en` / `rob_commit_dst_addr` / `rob_commit_dst_value`), so this block is the writer for the architectural register file.

## Interface
Parameters:
- `ROB_DEPTH`, 8: number of entries; must be a power of two and at least 2.
- `TAG_WIDTH`, 3: equals log2(`ROB_DEPTH`); width of the entry tag.

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `alloc_valid`  in  1  dispatch requests an entry this cycle.
- `alloc_has_dst`  in  1  the instruction writes a GPR.
- `alloc_dst_addr`  in  `GPR_ADDR_WIDTH`  destination GPR index.
- `alloc_ready`  out  1  an entry can be accepted this cycle.
- `alloc_tag`  out  `TAG_WIDTH`  tag given to the instruction; equals the tail index.
- `wb_valid`  in  1  an execution unit returns a result.
- `wb_tag`  in  `TAG_WIDTH`  entry that completes.
- `wb_value`  in  `WORD_WIDTH`  result data.
- `flush`  in  1  discards all entries (mispredict or exception).
- `commit_valid`  out  1  the head entry retires this cycle.
- `commit_tag`  out  `TAG_WIDTH`  tag of the retiring entry.
- `commit_en`  out  1  GPR write enable.
- `rob_commit_dst_addr`  out  `GPR_ADDR_WIDTH`  GPR write index.
- `rob_commit_dst_value`  out  `WORD_WIDTH`  GPR write data.
- `rob_empty`  out  1  no valid entries.
- `rob_count`  out  `TAG_WIDTH`+1  number of occupied entries.

## Operation
- Each entry holds: `valid`, `done`, `has_dst`, `dst_addr`, and `value`.
- Head and tail pointers are `TAG_WIDTH` bits wide and wrap modulo `ROB_DEPTH`. Occupancy is tracked by `rob_count`.
- **Allocate:** an allocation fires when `alloc_valid && alloc_ready`, with `alloc_ready = (rob_count != ROB_DEPTH)`.
  - The entry at tail is written with `valid=1` and `done=0`, and tail increments.
  - A full buffer refuses allocation even if a commit happens in the same cycle. Space freed by a commit is not reused in that cycle.
- **Writeback:** a writeback to an entry with `valid && !done` sets `done=1` and stores `wb_value`.
  - A writeback to an invalid entry is ignored.
  - A writeback to an entry that is already done is ignored; the first value wins.
- **Commit:** `commit_valid = head.valid && head.done && !flush`.
  - `commit_en = commit_valid && head.has_dst && (head.dst_addr != 0)`. Writes to x0 are never issued.
  - The address and value outputs carry head fields when `commit_en=1`, and zero otherwise.
  - On the edge, the head entry's `valid` is cleared and head increments.
- **Simultaneous allocate and commit:** `rob_count` is unchanged. Allocate only: +1. Commit only: −1.
- **Flush:** flush takes priority over allocate, writeback and commit in the same cycle.
  - All `valid` bits clear, head=tail=0, and `rob_count=0`.
  - `commit_valid` and `commit_en` are 0 during the flush cycle.
- **Reset:** all entries are invalid and the pointers are 0.
  - `alloc_ready=1`, `rob_empty=1`, `rob_count=0`, `alloc_tag=0`.
  - All commit outputs are 0.
  - Reset mid-operation drops all in-flight entries silently.

## Timing
- All outputs are combinational from registered state, plus `flush`. Under `ROB_WB_BYPASS_EN`, `wb_*` is also an input to this logic.
- Writeback at cycle N: the entry becomes done at edge N. Without bypass, `commit_en` can rise at the earliest in cycle N+1.
- Allocation at cycle N makes the entry visible at head no earlier than cycle N+1.
- Commit throughput is one entry per cycle. Commit order is strictly program order.

## Configuration
- `ROB_WB_BYPASS_EN` defined: when `wb_valid` targets the head entry and that entry is `valid && !done`, it commits in the same cycle N.
  - `rob_commit_dst_value = wb_value` in that case.
  - The entry retires at edge N without passing through the `done` state.
- Not defined: commits use registered `done` and `value` only, with a one-cycle minimum from writeback to commit.

## Structure
- `WORD_WIDTH` and `GPR_ADDR_WIDTH` come from the shared defines header.
- A `ROB_DEPTH` default and the entry-field widths belong in the same header.
- Single module with no sub-module. Pointer and count logic is too small to split out.

## Test plan
- **Reset then a single instruction:** allocate dst=5 (tag 0), then writeback tag 0 with 0xDEADBEEF. Required: `commit_en=1` with addr 5 and value 0xDEADBEEF one cycle later, then `rob_empty=1`.
- **Out-of-order completion:** allocate tags 0, 1, 2; write back 2, then 1, then 0. Required: commits in order 0, 1, 2 on consecutive cycles after tag 0 completes.
- **Full and wrap:**
  - Allocate 8 entries: `alloc_ready=0` and `rob_count=8`.
  - Commit one and allocate in the same cycle: the allocation is refused.
  - Allocate in the next cycle: the entry gets tag 0 (wrap).
- **x0 and no-dst:** an entry with dst=0 and one with `has_dst=0` each retire with `commit_valid=1` and `commit_en=0`.
- **Flush with ready head:** assert flush while the head is done. Required: no commit that cycle, then `rob_count=0`, the next `alloc_tag=0`, and a late writeback to an old tag has no effect.
- **Bypass (with `ROB_WB_BYPASS_EN`):** writeback to head tag 3 with 0x1234 at cycle N. Required: `commit_en=1` with value 0x1234 in cycle N.
